// File: rtl/button_debounce_pkg.sv
// Shared definitions for the button debouncer and its benches:
// handshake state encoding, default parameters and logic levels.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ          = 2'd1,
        ACKED        = 2'd2,
        WAIT_RELEASE = 2'd3
    } hs_state_e;

    localparam int DEF_CLOCK_SCALER_BITS = 16;
    localparam int DEF_STABLE_SAMPLES    = 4;
    localparam int DEF_REPEAT_TICKS      = 32;

    localparam int STABLE_W = 4;
    localparam int REPEAT_W = 8;

    localparam logic LEVEL_HIGH = 1'b1;
    localparam logic LEVEL_LOW  = 1'b0;

endpackage

// File: rtl/clock_scaler.sv
// Free-running prescaler producing a one-cycle sampling tick.
// Ports: clk_i, rst_i (async, active-high), tick_o (one pulse per 2^BITS clocks).
module clock_scaler #(
    parameter int BITS = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    logic [BITS-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + BITS'(1);
        tick_d = (cnt_q == '1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/button_request_debouncer.sv
// Synchronises and debounces a push button and turns each press into one
// four-phase req/ack handshake toward a responder.
// Ports: systemClock, reset (async, active-high), button (raw), ack (from
// responder), req (four-phase request), pressed (debounced level),
// debouncingClock (sampling tick).
// Build option: AUTO_REPEAT_EN re-issues requests while the button stays held.
module button_request_debouncer
    import button_debounce_pkg::*;
#(
    parameter int CLOCK_SCALER_BITS = DEF_CLOCK_SCALER_BITS,
    parameter int STABLE_SAMPLES    = DEF_STABLE_SAMPLES,
    parameter int REPEAT_TICKS      = DEF_REPEAT_TICKS
) (
    input  logic systemClock,
    input  logic reset,
    input  logic button,
    input  logic ack,
    output logic req,
    output logic pressed,
    output logic debouncingClock
);

    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(STABLE_SAMPLES);

    logic                tick;
    logic                sync1_q, sync2_q;
    logic                buttonSync;
    logic [STABLE_W-1:0] stable_q, stable_d, stable_inc;
    logic                pressed_q, pressed_d;
    hs_state_e           state_q, state_d;
    logic                req_q, req_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [REPEAT_W-1:0] REP_MAX = REPEAT_W'(REPEAT_TICKS);
    logic [REPEAT_W-1:0] rep_q, rep_d, rep_inc;
    assign rep_inc = rep_q + REPEAT_W'(1);
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_W'(REPEAT_TICKS);
`endif

    clock_scaler #(
        .BITS(CLOCK_SCALER_BITS)
    ) u_clock_scaler (
        .clk_i (systemClock),
        .rst_i (reset),
        .tick_o(tick)
    );

    assign buttonSync = sync2_q;
    assign stable_inc = stable_q + STABLE_W'(1);

    // Debounce: count consecutive ticks that disagree with pressed.
    always_comb begin
        stable_d  = stable_q;
        pressed_d = pressed_q;
        if (tick) begin
            if (buttonSync == pressed_q) begin
                stable_d = '0;
            end else if (stable_inc == STABLE_MAX) begin
                stable_d  = '0;
                pressed_d = ~pressed_q;
            end else begin
                stable_d = stable_inc;
            end
        end
    end

    // Handshake: req stays up until acked even if the button is released.
    always_comb begin
        state_d = state_q;
`ifdef AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pressed_q && !ack) state_d = REQ;
            end
            REQ: begin
                if (ack) state_d = ACKED;
            end
            ACKED: begin
                if (!ack) begin
                    state_d = WAIT_RELEASE;
`ifdef AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end
            end
            WAIT_RELEASE: begin
                if (!pressed_q) begin
                    state_d = IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (tick) begin
                    if (rep_inc == REP_MAX) begin
                        rep_d = '0;
                        if (!ack) state_d = REQ;
                    end else begin
                        rep_d = rep_inc;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge systemClock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= '0;
            pressed_q <= 1'b0;
            state_q   <= IDLE;
            req_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pressed_q <= pressed_d;
            state_q   <= state_d;
            req_q     <= req_d;
`ifdef AUTO_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign req             = req_q;
    assign pressed         = pressed_q;
    assign debouncingClock = tick;

endmodule

// File: tb/tb_button_request_debouncer.sv
// Bench for button_request_debouncer: directed vector table, hand-written
// handshake sequences and randomized stimulus against a reference model.
module tb_button_request_debouncer;
    import button_debounce_pkg::*;

    localparam int CSB    = 2;
    localparam int SS     = 3;
    localparam int RT     = 4;
    localparam int PERIOD = 1 << CSB;

    typedef struct {
        int   cycles;
        logic b;
        logic a;
        logic exp_req;
        logic exp_pressed;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button = 1'b0;
    logic ack = 1'b0;
    logic req, pressed, dclk;

    always #5 clk = ~clk;

    button_request_debouncer #(
        .CLOCK_SCALER_BITS(CSB),
        .STABLE_SAMPLES   (SS),
        .REPEAT_TICKS     (RT)
    ) dut (
        .systemClock    (clk),
        .reset          (rst),
        .button         (button),
        .ack            (ack),
        .req            (req),
        .pressed        (pressed),
        .debouncingClock(dclk)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic m_s1, m_s2, m_tick, m_pressed;
    logic m_req, m_wait_ack_low, m_wait_rel;
    int   m_cnt, m_rep;
    bit   m_run[$];

    int   d_rises, m_rises;
    logic d_prev, mr_prev;

    vec_t tbl[15];
    logic a_drv, b_drv;
    int   since, hold, len, waited;
    logic first_ack;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_tick = 0; m_pressed = 0;
        m_req = 0; m_wait_ack_low = 0; m_wait_rel = 0;
        m_cnt = 0; m_rep = 0;
        m_run.delete();
        d_prev = 0; mr_prev = 0;
    endtask

    // One clock of behaviour; all decisions use pre-edge values.
    task automatic model_step(input logic b, input logic a);
        logic n_pressed;
        n_pressed = m_pressed;
        if (m_tick) begin
            // run of consecutive samples disagreeing with the debounced level
            if (m_s2 != m_pressed) m_run.push_back(m_s2);
            else m_run.delete();
            if (m_run.size() == SS) begin
                n_pressed = ~m_pressed;
                m_run.delete();
            end
        end
        if (m_req) begin
            if (a) begin
                m_req = 0;
                m_wait_ack_low = 1;
            end
        end else if (m_wait_ack_low) begin
            if (!a) begin
                m_wait_ack_low = 0;
                m_wait_rel = 1;
                m_rep = 0;
            end
        end else if (m_wait_rel) begin
            if (!m_pressed) begin
                m_wait_rel = 0;
            end
`ifdef AUTO_REPEAT_EN
            else if (m_tick) begin
                m_rep++;
                if (m_rep == RT) begin
                    m_rep = 0;
                    if (!a) begin
                        m_wait_rel = 0;
                        m_req = 1;
                    end
                end
            end
`endif
        end else if (m_pressed && !a) begin
            m_req = 1;
        end
        m_tick    = (m_cnt == PERIOD - 1);
        m_cnt     = (m_cnt + 1) % PERIOD;
        m_s2      = m_s1;
        m_s1      = b;
        m_pressed = n_pressed;
    endtask

    task automatic step(input logic b, input logic a);
        button = b;
        ack    = a;
        @(posedge clk);
        model_step(b, a);
        @(negedge clk);
        chk("req", req, m_req);
        chk("pressed", pressed, m_pressed);
        chk("tick", dclk, m_tick);
        if (req && !d_prev) d_rises++;
        if (m_req && !mr_prev) m_rises++;
        d_prev  = req;
        mr_prev = m_req;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst    = 1'b1;
        button = 1'b0;
        ack    = 1'b0;
        model_reset();
        repeat (n) begin
            @(negedge clk);
            chk("rst_req", req, 1'b0);
            chk("rst_pressed", pressed, 1'b0);
            chk("rst_tick", dclk, 1'b0);
        end
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{12, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{3,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{2,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{11, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{12, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{16, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1,  1'b1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{20, 0, 0, 0, 0};

        model_reset();
        d_rises = 0;
        m_rises = 0;

        // Reset, then tick every 4th clock with outputs idle
        do_reset(10);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b0);
            chk("tick_phase", dclk, (k % 4 == 0));
        end

        // Directed vector table from a known prescaler phase
        do_reset(2);
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < tbl[r].cycles; c++) step(tbl[r].b, tbl[r].a);
            chk($sformatf("tbl%0d_req", r), req, tbl[r].exp_req);
            chk($sformatf("tbl%0d_pressed", r), pressed, tbl[r].exp_pressed);
        end

        // Held button, responder acks 3 clocks after req for 2 clocks
        do_reset(2);
        d_rises = 0; m_rises = 0;
        a_drv = 0; since = 0; hold = 0;
        for (int i = 0; i < 70; i++) begin
            first_ack = 0;
            if (a_drv) begin
                hold++;
                if (hold >= 2) begin a_drv = 0; hold = 0; end
            end else if (req) begin
                since++;
                if (since >= 3) begin a_drv = 1; since = 0; first_ack = 1; end
            end else begin
                since = 0;
            end
            step(i < 40, a_drv);
            if (first_ack) chk("req_fall_after_ack", req, 1'b0);
        end
`ifdef AUTO_REPEAT_EN
        chk_int("hold40_rises", d_rises, m_rises);
`else
        chk_int("hold40_rises", d_rises, 1);
`endif

        // Short press released before ack: req is sticky
        do_reset(2);
        d_rises = 0; m_rises = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        waited = 0;
        while (!req && waited < 40) begin
            step(1'b0, 1'b0);
            waited++;
        end
        chk("short_req_seen", req, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("short_req_sticky", req, 1'b1);
        step(1'b0, 1'b1);
        chk("short_req_fall", req, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        chk_int("short_rises", d_rises, 1);

        // Reset while in REQ
        do_reset(2);
        waited = 0;
        while (!req && waited < 40) begin
            step(1'b1, 1'b0);
            waited++;
        end
        chk("pre_reset_req", req, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_req", req, 1'b0);
        chk("async_rst_pressed", pressed, 1'b0);
        chk("async_rst_state", dut.state_q == IDLE, 1'b1);
        model_reset();
        button = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        d_rises = 0; m_rises = 0;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        chk_int("no_replay", d_rises, 0);

        // Long hold with prompt ack: auto-repeat count
        do_reset(2);
        d_rises = 0; m_rises = 0;
        for (int i = 0; i < 100; i++) step(1'b1, req);
        for (int i = 0; i < 30; i++) step(1'b0, req);
`ifdef AUTO_REPEAT_EN
        chk("repeat_multi", d_rises >= 3, 1'b1);
        chk_int("repeat_rises", d_rises, m_rises);
`else
        chk_int("hold100_rises", d_rises, 1);
`endif

        // Randomized button segments and ack toggling
        do_reset(2);
        a_drv = 0;
        for (int seg = 0; seg < 80; seg++) begin
            b_drv = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) a_drv = ~a_drv;
                step(b_drv, a_drv);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
